lzs_bitpack: RTL and testbench
==============================

# lzs_bitpack

LZS output bit packer: sits directly downstream of the encode datapath / match engine. It accepts one token per handshake (literal, match, or end-of-stream), encodes it into the LZS variable-length bit code, and packs the bits MSB-first into 64-bit words for the output FIFO. On end-of-stream it appends the LZS end marker, zero-pads to a byte boundary, flushes the partial word with a valid-byte count, and raises `done`.

## Interface
- `LZF_WIDTH`, 20, width of the compressed-byte counter
- `clk  in  1  clock`
- `rst  in  1  reset, asynchronous, active-high`
- `tok_valid  in  1  token present`
- `tok_ready  out  1  token accepted on clk when tok_valid&&tok_ready`
- `tok_end  in  1  end-of-stream token; other token fields ignored`
- `tok_type  in  1  0 literal, 1 match`
- `tok_lit  in  8  literal byte`
- `tok_off  in  11  match offset, legal 1..2047`
- `tok_len  in  5  match length, legal 2..22`
- `fo_full  in  1  output FIFO cannot take a write this cycle`
- `fo_wen  out  1  write strobe (combinational from regs and fo_full)`
- `fo_data  out  64  packed word, first bit at [63]`
- `fo_bytes  out  4  valid bytes in fo_data from [63:56] down, 1..8`
- `fo_last  out  1  final word of stream`
- `out_cnt  out  LZF_WIDTH  total bytes written, wraps modulo 2^LZF_WIDTH`
- `err  out  1  sticky illegal-token flag`
- `done  out  1  stream fully flushed`

## Operation
- Codes (transmitted MSB first):
  - Literal: `0` + 8-bit byte (9 bits).
  - Match: `1`; then either `1` + off[6:0] when off<128, or `0` + off[10:0].
  - Length: 2=`00`, 3=`01`, 4=`10`, 5=`1100`, 6=`1101`, 7=`1110`, 8..22=`1111` + (len-8)[3:0].
  - Maximum code is 21 bits.
  - End marker: `110000000` (9 bits).
- Bit buffer: 128-bit `bbuf`, filled from bit 127 down; `cnt` ranges 0..84.
  - An accepted token's code is placed immediately below the existing bits.
  - `cnt` increases by the code length.
- States:
  - `S_RUN` (reset state): `tok_ready = (cnt<64)`.
    - Accepted `tok_end` appends the marker and goes to `S_FLUSH`.
  - `S_FLUSH`: `tok_ready=0`.
    - On the first cycle, `cnt` is rounded up to a multiple of 8; pad bits are 0.
    - Drains as below.
    - When `cnt==0` after a write, go to `S_DONE`.
  - `S_DONE`: `done=1`, `tok_ready=0`. Held until `rst`.
- Drain rules:
  - In `S_RUN`: `fo_wen = (cnt>=64) && !fo_full`.
  - In `S_FLUSH` (after padding): `fo_wen = (cnt>0) && !fo_full`.
  - `fo_data = bbuf[127:64]`.
  - `fo_bytes = min(cnt,64)/8`.
  - `fo_last = S_FLUSH && cnt<=64`.
  - On a write: `bbuf` shifts left by 64, `cnt -= min(cnt,64)`, and `out_cnt += fo_bytes`.
- Token acceptance and drain are mutually exclusive in one cycle: `tok_ready` requires `cnt<64`.
- Illegal tokens set `err`; the token is consumed but nothing is appended. Illegal means either:
  - a match with `tok_off==0`, or
  - a match with `tok_len` outside 2..22.
- After padding, a stream ending exactly on a 64-bit boundary emits its last full word with `fo_bytes=8` and `fo_last=1`.
- Unused low bits of `fo_data` are 0.

## Timing
- Reset values:
  - `cnt=0`, `bbuf=0`, state `S_RUN`.
  - `tok_ready=1` (`cnt<64` in `S_RUN`).
  - `fo_wen=0`, `fo_data=0`, `fo_bytes=0`, `fo_last=0`, `out_cnt=0`, `err=0`, `done=0`.
- Latency: a token accepted at edge N is in `bbuf` after N. If that makes `cnt>=64`, `fo_wen` can assert in cycle N+1.
- `tok_end` accepted at edge N: the padding cycle is N+1; the first flush write can occur in cycle N+2.
- `fo_full` high holds `bbuf`/`cnt` and suppresses `fo_wen`; there is no data loss and no duplicate write.
- `tok_ready` depends only on registers (no combinational path from `tok_valid`).
- `rst` asserted mid-stream or mid-flush returns all state to reset values immediately; partial data is discarded.

## Test plan
- Literal 0x41 then `tok_end`, `fo_full=0` -> one write: `fo_data[63:40]=0x20E000`, rest 0, `fo_bytes=3`, `fo_last=1`; then `done=1`, `out_cnt=3`.
- Match off=5 len=2 then `tok_end` -> one write: `fo_data[63:40]=0xC29800`, `fo_bytes=3`, `fo_last=1`.
- Match off=1000 len=10 -> `bbuf[127:107]=0x13E8F2`, `cnt=21`. Also check len 5/6/7/22 codes `1100`/`1101`/`1110`/`11111110`.
- Eight literals 0xFF with `fo_full=1`:
  - after the 8th, `cnt=72`, `tok_ready=0`, `fo_wen=0` held for 10 cycles;
  - drop `fo_full` -> one write `fo_data=0x7FBFDFEFF7FBFDFE`, `fo_bytes=8`, `fo_last=0`, `cnt=8`, `tok_ready=1`.
- Match len=23, then match off=0 -> `err=1` after the first, `cnt` unchanged on both, `err` still 1 afterwards.
- Reset mid-flush (`fo_full=1` during `S_FLUSH`, pulse `rst`) -> all outputs at reset values, `tok_ready=1`; a new literal stream then packs from bit 127.

Source files
------------

// File: rtl/lzs_bitpack.sv
// LZS bit packer: encodes literal/match/end tokens into LZS variable-length codes
// and packs them MSB-first into 64-bit output words, flushing a padded tail at end-of-stream.
module lzs_bitpack #(
  parameter int LZF_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tok_valid,
  output logic                 tok_ready,
  input  logic                 tok_end,
  input  logic                 tok_type,
  input  logic [7:0]           tok_lit,
  input  logic [10:0]          tok_off,
  input  logic [4:0]           tok_len,
  input  logic                 fo_full,
  output logic                 fo_wen,
  output logic [63:0]          fo_data,
  output logic [3:0]           fo_bytes,
  output logic                 fo_last,
  output logic [LZF_WIDTH-1:0] out_cnt,
  output logic                 err,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t               r_state;
  logic                 r_pad;
  logic [127:0]         r_bbuf;
  logic [6:0]           r_cnt;
  logic [LZF_WIDTH-1:0] r_out_cnt;
  logic                 r_err;

  logic [25:0]  w_enc;
  logic [20:0]  w_code;
  logic [4:0]   w_n;
  logic [20:0]  w_code_l;
  logic [127:0] w_ins;
  logic [6:0]   w_take;
  logic         w_ready;
  logic         w_acc;
  logic         w_illegal;

  // Returns {code length, code right-aligned in 21 bits}; the end marker is
  // the short-offset match prefix with offset 0 and no length field.
  function automatic logic [25:0] f_encode(input logic        end_i,
                                           input logic        typ,
                                           input logic [7:0]  lit,
                                           input logic [10:0] off,
                                           input logic [4:0]  len);
    logic [20:0] code;
    logic [4:0]  n;
    logic [7:0]  lcode;
    logic [4:0]  ln;
    code  = '0;
    n     = '0;
    lcode = '0;
    ln    = '0;
    if (end_i) begin
      code = 21'h000180;
      n    = 5'd9;
    end else if (!typ) begin
      code = {13'b0, lit};
      n    = 5'd9;
    end else begin
      if (len <= 5'd4) begin
        lcode = {6'b0, 2'(len - 5'd2)};
        ln    = 5'd2;
      end else if (len <= 5'd7) begin
        lcode = {4'b0, 2'b11, 2'(len - 5'd5)};
        ln    = 5'd4;
      end else begin
        lcode = {4'b1111, 4'(len - 5'd8)};
        ln    = 5'd8;
      end
      if (off < 11'd128) begin
        code = {12'b0, 2'b11, off[6:0]};
        n    = 5'd9 + ln;
      end else begin
        code = {8'b0, 2'b10, off};
        n    = 5'd13 + ln;
      end
      code = (code << ln) | {13'b0, lcode};
    end
    return {n, code};
  endfunction

  function automatic logic f_illegal(input logic        typ,
                                     input logic [10:0] off,
                                     input logic [4:0]  len);
    return typ && ((off == 11'd0) || (len < 5'd2) || (len > 5'd22));
  endfunction

  assign w_enc     = f_encode(tok_end, tok_type, tok_lit, tok_off, tok_len);
  assign w_n       = w_enc[25:21];
  assign w_code    = w_enc[20:0];
  assign w_code_l  = w_code << (5'd21 - w_n);
  assign w_ins     = {w_code_l, 107'b0} >> r_cnt;
  assign w_illegal = f_illegal(tok_type, tok_off, tok_len);

  assign w_take  = (r_cnt >= 7'd64) ? 7'd64 : r_cnt;
  assign w_ready = (r_state == S_RUN) && (r_cnt < 7'd64);
  assign w_acc   = tok_valid && w_ready;

  assign tok_ready = w_ready;
  assign fo_wen    = !fo_full &&
                     (((r_state == S_RUN) && (r_cnt >= 7'd64)) ||
                      ((r_state == S_FLUSH) && !r_pad && (r_cnt != 7'd0)));
  assign fo_data   = r_bbuf[127:64];
  assign fo_bytes  = w_take[6:3];
  assign fo_last   = (r_state == S_FLUSH) && (r_cnt <= 7'd64);
  assign out_cnt   = r_out_cnt;
  assign err       = r_err;
  assign done      = (r_state == S_DONE);

  // A write and a token acceptance never coincide: acceptance needs cnt<64,
  // a RUN-state write needs cnt>=64, and FLUSH never accepts tokens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_pad     <= 1'b0;
      r_bbuf    <= '0;
      r_cnt     <= '0;
      r_out_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (fo_wen) begin
        r_bbuf    <= r_bbuf << 64;
        r_cnt     <= r_cnt - w_take;
        r_out_cnt <= r_out_cnt + LZF_WIDTH'(fo_bytes);
        if ((r_state == S_FLUSH) && (r_cnt == w_take)) r_state <= S_DONE;
      end else if (w_acc) begin
        if (tok_end) begin
          r_bbuf  <= r_bbuf | w_ins;
          r_cnt   <= r_cnt + {2'b0, w_n};
          r_state <= S_FLUSH;
          r_pad   <= 1'b1;
        end else if (w_illegal) begin
          r_err <= 1'b1;
        end else begin
          r_bbuf <= r_bbuf | w_ins;
          r_cnt  <= r_cnt + {2'b0, w_n};
        end
      end else if ((r_state == S_FLUSH) && r_pad) begin
        // Bits below cnt are always zero, so byte padding is a count change only.
        r_cnt <= (r_cnt + 7'd7) & 7'h78;
        r_pad <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lzs_bitpack.sv
// Bench for lzs_bitpack: code table vectors, backpressure/error/reset sequences,
// and random token streams checked against a bit-queue model of the LZS format.
module tb_lzs_bitpack;
  localparam int LZF_WIDTH = 20;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 tok_valid = 1'b0;
  logic                 tok_ready;
  logic                 tok_end = 1'b0;
  logic                 tok_type = 1'b0;
  logic [7:0]           tok_lit = '0;
  logic [10:0]          tok_off = '0;
  logic [4:0]           tok_len = '0;
  logic                 fo_full;
  logic                 fo_wen;
  logic [63:0]          fo_data;
  logic [3:0]           fo_bytes;
  logic                 fo_last;
  logic [LZF_WIDTH-1:0] out_cnt;
  logic                 err;
  logic                 done;

  int   full_mode = 0;
  logic rnd_full = 1'b0;
  assign fo_full = (full_mode == 1) || ((full_mode == 2) && rnd_full);

  lzs_bitpack #(.LZF_WIDTH(LZF_WIDTH)) dut (
    .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_end(tok_end), .tok_type(tok_type), .tok_lit(tok_lit), .tok_off(tok_off),
    .tok_len(tok_len), .fo_full(fo_full), .fo_wen(fo_wen), .fo_data(fo_data),
    .fo_bytes(fo_bytes), .fo_last(fo_last), .out_cnt(out_cnt), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_full = ($urandom_range(0, 2) == 0);
  end

  logic [63:0] cap_data[$];
  logic [3:0]  cap_bytes[$];
  logic        cap_last[$];

  always @(negedge clk) begin
    if (!rst && fo_wen) begin
      cap_data.push_back(fo_data);
      cap_bytes.push_back(fo_bytes);
      cap_last.push_back(fo_last);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the stream as a plain queue of bits in transmit order.
  bit   mq[$];
  logic exp_err;

  task automatic push_bits(input logic [20:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mq.push_back(v[i]);
  endtask

  task automatic model_token(input logic typ, input logic [7:0] lit,
                             input logic [10:0] off, input logic [4:0] len);
    int l;
    l = int'(len);
    if (typ && (off == 0 || l < 2 || l > 22)) begin
      exp_err = 1'b1;
    end else if (!typ) begin
      push_bits(21'(0), 1);
      push_bits(21'(lit), 8);
    end else begin
      push_bits(21'(1), 1);
      if (off < 128) begin
        push_bits(21'(1), 1);
        push_bits(21'(off), 7);
      end else begin
        push_bits(21'(0), 1);
        push_bits(21'(off), 11);
      end
      if (l <= 4) push_bits(21'(l - 2), 2);
      else if (l <= 7) push_bits(21'(12 + l - 5), 4);
      else push_bits(21'(240 + l - 8), 8);
    end
  endtask

  task automatic model_end();
    push_bits(21'h180, 9);
    while (mq.size() % 8 != 0) mq.push_back(1'b0);
  endtask

  task automatic compare_stream(input string name);
    int nb, nw, nwc, bw;
    logic [63:0] d;
    nb  = mq.size() / 8;
    nw  = (nb + 7) / 8;
    chk({name, " words"}, 64'(cap_data.size()), 64'(nw));
    nwc = (cap_data.size() < nw) ? cap_data.size() : nw;
    for (int w = 0; w < nwc; w++) begin
      bw = ((nb - 8 * w) > 8) ? 8 : (nb - 8 * w);
      d  = '0;
      for (int k = 0; k < bw * 8; k++) d[63 - k] = mq[64 * w + k];
      chk($sformatf("%s w%0d data", name, w), cap_data[w], d);
      chk($sformatf("%s w%0d bytes", name, w), 64'(cap_bytes[w]), 64'(bw));
      chk($sformatf("%s w%0d last", name, w), 64'(cap_last[w]), 64'(w == nw - 1));
    end
    chk({name, " out_cnt"}, 64'(out_cnt), 64'(nb % (1 << LZF_WIDTH)));
    chk({name, " err"}, 64'(err), 64'(exp_err));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    rst       = 1'b1;
    cap_data.delete();
    cap_bytes.delete();
    cap_last.delete();
    mq.delete();
    exp_err = 1'b0;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string name, input logic e, input logic typ, input logic [7:0] lit,
                      input logic [10:0] off, input logic [4:0] len);
    bit ok;
    ok        = 1'b0;
    tok_valid = 1'b1;
    tok_end   = e;
    tok_type  = typ;
    tok_lit   = lit;
    tok_off   = off;
    tok_len   = len;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (tok_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    tok_valid = 1'b0;
    tok_end   = 1'b0;
    if (!ok) chk({name, " accept timeout"}, 64'(0), 64'(1));
  endtask

  task automatic wait_done(input string name, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    chk({name, " done"}, 64'(done), 64'(1));
  endtask

  typedef struct {
    logic        typ;
    logic [7:0]  lit;
    logic [10:0] off;
    logic [4:0]  len;
    int          n;
    logic [20:0] code;
  } vec_t;

  vec_t vt[12];

  logic [63:0] e_word;
  int          e_bytes;
  int          ntok, r;
  logic        g_typ;
  logic [7:0]  g_lit;
  logic [10:0] g_off;
  logic [4:0]  g_len;
  int          viol;

  initial begin
    vt[0]  = '{1'b0, 8'h41, 11'd0,    5'd0,  9,  21'h000041};
    vt[1]  = '{1'b1, 8'h00, 11'd5,    5'd2,  11, 21'h000614};
    vt[2]  = '{1'b1, 8'h00, 11'd1000, 5'd10, 21, 21'h13E8F2};
    vt[3]  = '{1'b1, 8'h00, 11'd5,    5'd5,  13, 21'h00185C};
    vt[4]  = '{1'b1, 8'h00, 11'd5,    5'd6,  13, 21'h00185D};
    vt[5]  = '{1'b1, 8'h00, 11'd5,    5'd7,  13, 21'h00185E};
    vt[6]  = '{1'b1, 8'h00, 11'd5,    5'd22, 17, 21'h0185FE};
    vt[7]  = '{1'b1, 8'h00, 11'd127,  5'd3,  11, 21'h0007FD};
    vt[8]  = '{1'b1, 8'h00, 11'd128,  5'd4,  15, 21'h004202};
    vt[9]  = '{1'b1, 8'h00, 11'd2047, 5'd8,  21, 21'h17FFF0};
    vt[10] = '{1'b0, 8'h00, 11'd0,    5'd0,  9,  21'h000000};
    vt[11] = '{1'b0, 8'hFF, 11'd0,    5'd0,  9,  21'h0000FF};

    // Reset state observed while rst is held.
    #1;
    chk("rst tok_ready", 64'(tok_ready), 64'(1));
    chk("rst fo_wen", 64'(fo_wen), 64'(0));
    chk("rst fo_data", fo_data, 64'(0));
    chk("rst fo_bytes", 64'(fo_bytes), 64'(0));
    chk("rst fo_last", 64'(fo_last), 64'(0));
    chk("rst out_cnt", 64'(out_cnt), 64'(0));
    chk("rst err", 64'(err), 64'(0));
    chk("rst done", 64'(done), 64'(0));

    // Single-token code table: token followed by end marker in one padded word.
    full_mode = 0;
    for (int i = 0; i < 12; i++) begin
      do_reset();
      send($sformatf("vec%0d tok", i), 1'b0, vt[i].typ, vt[i].lit, vt[i].off, vt[i].len);
      send($sformatf("vec%0d end", i), 1'b1, 1'b0, 8'h00, 11'd0, 5'd0);
      wait_done($sformatf("vec%0d", i), 50);
      e_word  = ({43'b0, vt[i].code} << (64 - vt[i].n)) | (64'h180 << (55 - vt[i].n));
      e_bytes = (vt[i].n + 9 + 7) / 8;
      chk($sformatf("vec%0d words", i), 64'(cap_data.size()), 64'(1));
      if (cap_data.size() > 0) begin
        chk($sformatf("vec%0d data", i), cap_data[0], e_word);
        chk($sformatf("vec%0d bytes", i), 64'(cap_bytes[0]), 64'(e_bytes));
        chk($sformatf("vec%0d last", i), 64'(cap_last[0]), 64'(1));
      end
      chk($sformatf("vec%0d out_cnt", i), 64'(out_cnt), 64'(e_bytes));
      chk($sformatf("vec%0d err", i), 64'(err), 64'(0));
    end

    // Backpressure with a full first word pending.
    do_reset();
    full_mode = 1;
    for (int i = 0; i < 8; i++) send("ff lit", 1'b0, 1'b0, 8'hFF, 11'd0, 5'd0);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tok_ready || fo_wen) viol++;
    end
    chk("ff held", 64'(viol), 64'(0));
    @(posedge clk);
    #1;
    full_mode = 0;
    @(negedge clk);
    chk("ff wen", 64'(fo_wen), 64'(1));
    chk("ff data", fo_data, 64'h7FBFDFEFF7FBFDFE);
    chk("ff bytes", 64'(fo_bytes), 64'(8));
    chk("ff last", 64'(fo_last), 64'(0));
    @(posedge clk);
    #1;
    chk("ff wen after", 64'(fo_wen), 64'(0));
    chk("ff cnt8", 64'(fo_bytes), 64'(1));
    chk("ff ready", 64'(tok_ready), 64'(1));
    chk("ff out_cnt", 64'(out_cnt), 64'(8));

    // Illegal tokens are consumed without appending anything.
    do_reset();
    send("ill len", 1'b0, 1'b1, 8'h00, 11'd5, 5'd23);
    chk("ill err1", 64'(err), 64'(1));
    chk("ill fo_bytes", 64'(fo_bytes), 64'(0));
    send("ill off", 1'b0, 1'b1, 8'h00, 11'd0, 5'd3);
    chk("ill err2", 64'(err), 64'(1));
    send("ill lit", 1'b0, 1'b0, 8'h41, 11'd0, 5'd0);
    send("ill end", 1'b1, 1'b0, 8'h00, 11'd0, 5'd0);
    wait_done("ill", 50);
    chk("ill words", 64'(cap_data.size()), 64'(1));
    if (cap_data.size() > 0) chk("ill data", cap_data[0], 64'h20E000 << 40);
    chk("ill err3", 64'(err), 64'(1));

    // Asynchronous reset in the middle of a stalled flush.
    do_reset();
    full_mode = 1;
    send("mr ill", 1'b0, 1'b1, 8'h00, 11'd0, 5'd4);
    send("mr lit", 1'b0, 1'b0, 8'h41, 11'd0, 5'd0);
    send("mr end", 1'b1, 1'b0, 8'h00, 11'd0, 5'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("mr flush ready", 64'(tok_ready), 64'(0));
    chk("mr flush last", 64'(fo_last), 64'(1));
    rst = 1'b1;
    #1;
    chk("mr tok_ready", 64'(tok_ready), 64'(1));
    chk("mr fo_wen", 64'(fo_wen), 64'(0));
    chk("mr fo_data", fo_data, 64'(0));
    chk("mr fo_bytes", 64'(fo_bytes), 64'(0));
    chk("mr fo_last", 64'(fo_last), 64'(0));
    chk("mr out_cnt", 64'(out_cnt), 64'(0));
    chk("mr err", 64'(err), 64'(0));
    chk("mr done", 64'(done), 64'(0));
    #2;
    rst = 1'b0;
    full_mode = 0;
    @(posedge clk);
    #1;
    cap_data.delete();
    cap_bytes.delete();
    cap_last.delete();
    send("mr lit2", 1'b0, 1'b0, 8'h41, 11'd0, 5'd0);
    send("mr end2", 1'b1, 1'b0, 8'h00, 11'd0, 5'd0);
    wait_done("mr2", 50);
    chk("mr2 words", 64'(cap_data.size()), 64'(1));
    if (cap_data.size() > 0) begin
      chk("mr2 data", cap_data[0], 64'h20E000 << 40);
      chk("mr2 bytes", 64'(cap_bytes[0]), 64'(3));
    end
    chk("mr2 out_cnt", 64'(out_cnt), 64'(3));

    // Random streams under random backpressure.
    for (int s = 0; s < 25; s++) begin
      do_reset();
      full_mode = 2;
      ntok = $urandom_range(0, 30);
      for (int t = 0; t < ntok; t++) begin
        r     = $urandom_range(0, 99);
        g_typ = (r >= 45);
        g_lit = 8'($urandom);
        g_off = 11'($urandom_range(1, 2047));
        if ($urandom_range(0, 1) == 1) g_off = 11'($urandom_range(1, 127));
        g_len = 5'($urandom_range(2, 22));
        if (r >= 90 && r < 95) g_off = 11'd0;
        if (r >= 95) g_len = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 1))
                                                         : 5'($urandom_range(23, 31));
        model_token(g_typ, g_lit, g_off, g_len);
        send($sformatf("rnd%0d tok%0d", s, t), 1'b0, g_typ, g_lit, g_off, g_len);
      end
      model_end();
      send($sformatf("rnd%0d end", s), 1'b1, 1'b0, 8'h00, 11'd0, 5'd0);
      wait_done($sformatf("rnd%0d", s), 500);
      compare_stream($sformatf("rnd%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got no finish, required finish within 2000000");
    $fatal(1);
  end

endmodule
